// File: rtl/dma_xfer_ctrl.sv
// Single-channel DMA sequencer: reads LEN words from SRC in bursts of up to BURST,
// staging them in an external 8-deep FIFO, then writes them out to DST.
module dma_xfer_ctrl #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16,
  parameter int BURST  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack,
  output logic              fifo_clear,
  output logic              fifo_wr,
  output logic [31:0]       fifo_wdata,
  output logic              fifo_rd,
  input  logic [31:0]       fifo_rdata,
  input  logic              fifo_full,
  input  logic              fifo_empty
);

  localparam int                BC_W      = $clog2(BURST + 1);
  localparam logic [BC_W-1:0]   BURST_C   = BC_W'(BURST);
  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_POP, S_WRITE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]  rd_left_q, rd_left_d, wr_left_q, wr_left_d;
  logic [BC_W-1:0]   burst_q, burst_d;
  logic              gap_q, gap_d;

  assign bus_wdata  = fifo_rdata;
  assign fifo_wdata = bus_rdata;
  assign busy       = (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    rd_left_d  = rd_left_q;
    wr_left_d  = wr_left_q;
    burst_d    = burst_q;
    gap_d      = 1'b0;
    done       = 1'b0;
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = '0;
    fifo_clear = 1'b0;
    fifo_wr    = 1'b0;
    fifo_rd    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            src_d      = src_addr;
            dst_d      = dst_addr;
            rd_left_d  = len;
            wr_left_d  = len;
            burst_d    = '0;
            fifo_clear = 1'b1;
            state_d    = S_READ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_READ: begin
        // gap_q keeps bus_req low for the cycle right after any ack
        bus_addr = src_q;
        bus_req  = !fifo_full && !gap_q;
        if (bus_req && bus_ack) begin
          fifo_wr   = 1'b1;
          src_d     = src_q + WORD_STEP;
          rd_left_d = rd_left_q - 1'b1;
          burst_d   = burst_q + 1'b1;
          gap_d     = 1'b1;
          if (burst_d == BURST_C || rd_left_d == '0) state_d = S_POP;
        end
      end
      S_POP: begin
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        bus_we   = 1'b1;
        bus_addr = dst_q;
        bus_req  = !gap_q;
        if (bus_req && bus_ack) begin
          dst_d     = dst_q + WORD_STEP;
          wr_left_d = wr_left_q - 1'b1;
          burst_d   = burst_q - 1'b1;
          gap_d     = 1'b1;
          if (burst_d != '0)        state_d = S_POP;
          else if (wr_left_d == '0) state_d = S_DONE;
          else                      state_d = S_READ;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort discards any ack seen this cycle and leaves the counters untouched.
    if (abort && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      src_d      = src_q;
      dst_d      = dst_q;
      rd_left_d  = rd_left_q;
      wr_left_d  = wr_left_q;
      burst_d    = burst_q;
      gap_d      = 1'b0;
      done       = 1'b0;
      bus_req    = 1'b0;
      fifo_wr    = 1'b0;
      fifo_rd    = 1'b0;
      fifo_clear = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      rd_left_q <= '0;
      wr_left_q <= '0;
      burst_q   <= '0;
      gap_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rd_left_q <= rd_left_d;
      wr_left_q <= wr_left_d;
      burst_q   <= burst_d;
      gap_q     <= gap_d;
    end
  end

endmodule
